// File: rtl/serial_tx_uart_pkg.sv
// Shared definitions for the serial transmit back end: FSM encodings, frame width
// and the default baud divisor for a 50 MHz clock at 115200 baud.
package serial_tx_uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serial_tx_uart_byte_fifo.sv
// Circular byte FIFO with a combinational head. Full/empty come from the registered
// count, so a push while full is dropped even if a pop happens on the same edge.
module byte_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_tx_uart.sv
// 8N1 UART transmitter fed by a byte FIFO. Handshake: a byte is accepted on any rising
// edge with wr_en_in=1 while ready_out=1; writes while full are dropped and flagged.
module serial_tx_uart
    import serial_tx_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         wr_data_in,
    input  logic               wr_en_in,
    output logic               ready_out,
    output logic               tx_out,
    output logic               busy_out,
    output logic [FIFO_AW:0]   fifo_count_out,
    output logic               overflow_out,
    output tx_state_e          state_out
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_e   state, state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shift_reg, shift_n;
    logic        tx_reg, tx_n;
    logic        overflow;
    logic        baud_done;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    byte_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_en_in),
        .pop   (fifo_pop),
        .din   (wr_data_in),
        .dout  (fifo_dout),
        .count (fifo_count_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_done    = (baud_cnt == BAUD_LAST);
    assign ready_out    = !fifo_full;
    assign tx_out       = tx_reg;
    assign busy_out     = (state != S_IDLE);
    assign overflow_out = overflow;
    assign state_out    = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_idx   <= bit_n;
            shift_reg <= shift_n;
            tx_reg    <= tx_n;
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        shift_n  = shift_reg;
        tx_n     = tx_reg;
        fifo_pop = 1'b0;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_dout;
                    baud_n   = '0;
                    tx_n     = 1'b0;
                    state_n  = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    tx_n    = shift_reg[0];
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        tx_n    = 1'b1;
                        state_n = S_STOP;
                    end else begin
                        // Next line level is the bit that becomes shift[0] after this shift.
                        shift_n = shift_reg >> 1;
                        tx_n    = shift_reg[1];
                        bit_n   = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                      overflow <= 1'b0;
        else if (wr_en_in && fifo_full) overflow <= 1'b1;
    end

endmodule
